rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback sources.
//   Source P is the in-order pipeline writeback (rd/data/wen after writeback select).
//   Source L is the long-latency result path (multiplier/divider, late CSR results).
//   P has priority; an aging counter guarantees L a slot after MAX_WAIT lost cycles.
//   The winning write is registered and driven to the regfile one cycle later.
//   Writes to x0 are accepted but never asserted on rf_wen.
// PARAMETERS
//   DATA_W    32  width of write data
//   ADDR_W    5   width of register address
//   MAX_WAIT  4   cycles L may lose arbitration before it is forced through (0 = L always wins)
//   CNT_W     16  width of conflict performance counter
// PORTS
//   clk         in   1       clock, all state on rising edge
//   rst         in   1       reset, asynchronous, active-low
//   p_valid     in   1       pipeline write request
//   p_ready     out  1       pipeline request accepted this cycle when p_valid=1
//   p_rd        in   ADDR_W  pipeline destination register
//   p_data      in   DATA_W  pipeline write data
//   l_valid     in   1       long-latency write request
//   l_ready     out  1       long-latency request accepted this cycle when l_valid=1
//   l_rd        in   ADDR_W  long-latency destination register
//   l_data      in   DATA_W  long-latency write data
//   rf_wen      out  1       regfile write enable (registered)
//   rf_waddr    out  ADDR_W  regfile write address (registered)
//   rf_wdata    out  DATA_W  regfile write data (registered)
//   conflict_cnt out CNT_W   cycles with p_valid&l_valid, saturating
// BEHAVIOUR
//   Reset (rst=0, async): rf_wen=0, rf_waddr=0, rf_wdata=0, wait_cnt=0, conflict_cnt=0.
//   force_l = l_valid & (wait_cnt >= MAX_WAIT).
//   p_ready = ~force_l;  l_ready = force_l | ~p_valid  (both combinational, no valid->ready loop on own side).
//   p_fire = p_valid&p_ready; l_fire = l_valid&l_ready; never both in one cycle.
//   Requesters hold valid/rd/data stable until their fire; arbiter does not check this.
//   wait_cnt: l_fire or ~l_valid -> 0; l_valid&~l_ready -> +1, saturates at MAX_WAIT.
//   Output register, cycle after fire: rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=data of winner.
//   No fire: rf_wen<=0; rf_waddr/rf_wdata hold last value.
//   x0 write: request fires normally (ready/aging unaffected), rf_wen stays 0 next cycle.
//   Same rd from P then L on consecutive fires: both written in fire order, later wins.
//   conflict_cnt: +1 each cycle p_valid&l_valid; stops at all-ones.
//   Reset mid-operation: pending requests dropped, registered write discarded, aging restarts at 0.
//   Latency: fire in cycle N -> rf_wen high in cycle N+1; throughput one write per cycle.
// TESTING
//   P alone: p_valid=1,p_rd=5,p_data=0x1234 -> p_ready=1; next cycle rf_wen=1,waddr=5,wdata=0x1234.
//   Conflict: p_valid,l_valid held high, MAX_WAIT=4 -> P fires 4 cycles, 5th cycle l_ready=1,p_ready=0, L written next cycle.
//   x0: l_valid=1,l_rd=0,l_data=0xFFFF -> l_ready=1; next cycle rf_wen=0, waddr=0.
//   Back-to-back: P rd=3 0xA, then L rd=3 0xB in next cycle -> rf writes 0xA then 0xB, final x3=0xB.
//   Async reset: assert rst=0 mid-conflict (wait_cnt=3) -> outputs 0 immediately, after release L waits 4 again.
//   Counter saturation: CNT_W=4, 20 conflict cycles -> conflict_cnt=15.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P) has priority, and the
// long-latency path (L) is forced through after losing MAX_WAIT consecutive cycles.
module rf_wport_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [ADDR_W-1:0] p_rd,
  input  logic [DATA_W-1:0] p_data,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [ADDR_W-1:0] l_rd,
  input  logic [DATA_W-1:0] l_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              force_l;
  logic              p_fire;
  logic              l_fire;

  // L is forced once it has been starved for MAX_WAIT cycles; P yields only then.
  always_comb begin
    force_l = l_valid && (wait_cnt >= WAIT_MAX);
    p_ready = ~force_l;
    l_ready = force_l | ~p_valid;
    p_fire  = p_valid & p_ready;
    l_fire  = l_valid & l_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!l_valid || l_fire) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Address and data hold between writes; only the enable drops on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (p_fire) begin
      rf_wen   <= (p_rd != '0);
      rf_waddr <= p_rd;
      rf_wdata <= p_data;
    end else if (l_fire) begin
      rf_wen   <= (l_rd != '0);
      rf_waddr <= l_rd;
      rf_wdata <= l_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (p_valid && l_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter; a second instance with a 4-bit
// conflict counter shares the stimulus to exercise saturation.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_valid = 1'b0;
  logic [4:0]  p_rd = '0;
  logic [31:0] p_data = '0;
  logic        l_valid = 1'b0;
  logic [4:0]  l_rd = '0;
  logic [31:0] l_data = '0;

  logic        p_ready, l_ready, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;

  logic        s_p_ready, s_l_ready, s_rf_wen;
  logic [4:0]  s_rf_waddr;
  logic [31:0] s_rf_wdata;
  logic [3:0]  s_conflict_cnt;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];
  logic [31:0] last_x3 = '0;

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  rf_wport_arbiter #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(s_p_ready), .p_rd(p_rd), .p_data(p_data),
    .l_valid(l_valid), .l_ready(s_l_ready), .l_rd(l_rd), .l_data(l_data),
    .rf_wen(s_rf_wen), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .conflict_cnt(s_conflict_cnt)
  );

  task automatic check_output(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check combinational readies,
  // and queue the register write that the hand-computed winner should produce.
  task automatic apply_stimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic exp_pr, input logic exp_lr);
    @(negedge clk);
    p_valid = pv; p_rd = prd; p_data = pd;
    l_valid = lv; l_rd = lrd; l_data = ld;
    #1;
    check_output("p_ready", {36'd0, p_ready}, {36'd0, exp_pr});
    check_output("l_ready", {36'd0, l_ready}, {36'd0, exp_lr});
    if (pv && exp_pr) begin
      if (prd != 5'd0) exp_q.push_back({prd, pd});
    end else if (lv && exp_lr) begin
      if (lrd != 5'd0) exp_q.push_back({lrd, ld});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
  endtask

  // Monitor: every asserted write must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst && rf_wen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h expected none", rf_waddr, rf_wdata);
      end else begin
        check_output("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
      end
      if (rf_waddr == 5'd3) last_x3 = rf_wdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p_idx;
    // Reset state
    #12;
    check_output("reset_wen", {36'd0, rf_wen}, 37'd0);
    check_output("reset_waddr", {32'd0, rf_waddr}, 37'd0);
    check_output("reset_wdata", {5'd0, rf_wdata}, 37'd0);
    check_output("reset_cnt", {21'd0, conflict_cnt}, 37'd0);
    @(negedge clk);
    rst = 1'b1;

    // P alone
    apply_stimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(2);

    // Conflict: P wins four cycles, L forced on the fifth, P resumes with held request
    apply_stimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hBEEF, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'hBEEF, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hBEEF, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hBEEF, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd9, 32'hBEEF, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(2);
    check_output("conflict_cnt_5", {21'd0, conflict_cnt}, 37'd5);
    check_output("small_cnt_5", {33'd0, s_conflict_cnt}, 37'd5);

    // x0 write from L: fires but never enables the regfile
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_output("x0_wen", {36'd0, rf_wen}, 37'd0);
    check_output("x0_waddr", {32'd0, rf_waddr}, 37'd0);
    idle(1);

    // Back-to-back same rd, later write wins
    apply_stimulus(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hB, 1'b1, 1'b1);
    idle(2);
    check_output("final_x3", {5'd0, last_x3}, 37'hB);

    // Async reset mid-conflict after three lost L cycles
    apply_stimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd12, 32'hC0DE, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd11, 32'h101, 1'b1, 5'd12, 32'hC0DE, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd13, 32'h102, 1'b1, 5'd12, 32'hC0DE, 1'b1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_output("async_wen", {36'd0, rf_wen}, 37'd0);
    check_output("async_waddr", {32'd0, rf_waddr}, 37'd0);
    check_output("async_wdata", {5'd0, rf_wdata}, 37'd0);
    check_output("async_cnt", {21'd0, conflict_cnt}, 37'd0);
    p_valid = 1'b0; l_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 5'd14, 32'h200, 1'b1, 5'd15, 32'hD00D, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd16, 32'h201, 1'b1, 5'd15, 32'hD00D, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd17, 32'h202, 1'b1, 5'd15, 32'hD00D, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd18, 32'h203, 1'b1, 5'd15, 32'hD00D, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd19, 32'h204, 1'b1, 5'd15, 32'hD00D, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd19, 32'h204, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(2);
    check_output("post_reset_cnt", {21'd0, conflict_cnt}, 37'd5);

    // Saturation: 20 conflict cycles, repeating P,P,P,P,L pattern
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    p_idx = 0;
    for (int i = 0; i < 20; i++) begin
      if ((i % 5) == 4) begin
        apply_stimulus(1'b1, 5'd20, 32'h300 + p_idx, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
      end else begin
        apply_stimulus(1'b1, 5'd20, 32'h300 + p_idx, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
        p_idx++;
      end
    end
    idle(3);
    check_output("sat_cnt_main", {21'd0, conflict_cnt}, 37'd20);
    check_output("sat_cnt_small", {33'd0, s_conflict_cnt}, 37'd15);
    check_output("queue_drained", 37'(exp_q.size()), 37'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
